huff_bit_packer: RTL

- Downstream stage of the Huffman encoder. Consumes one variable-length codeword per handshake as a (code, length) pair.
- Packs codewords MSB-first into fixed-width output words with valid/ready flow control.
- On request, flushes a final partial word, zero-padded, and reports how many of its bits are valid.
- Sits between huff_encoder and the chip's output pins / serializer.

---
 rtl/huff_bit_packer.sv | 117 +++++++++++
 1 files changed

// File: rtl/huff_bit_packer.sv
// Packs variable-length (code, len) pairs MSB-first into OUT_W-bit words.
// A flush drains every buffered bit, ending with a zero-padded partial word.
module huff_bit_packer #(
  parameter  int MAX_LEN = 8,
  parameter  int OUT_W   = 8,
  parameter  int ACC_W   = 16,
  localparam int LW      = $clog2(MAX_LEN + 1),
  localparam int NW      = $clog2(OUT_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] code_in,
  input  logic [LW-1:0]      len_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [OUT_W-1:0]   out_data,
  output logic [NW-1:0]      out_nbits,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               flush_done
);

  localparam int CW = $clog2(ACC_W + 1);
  localparam logic [CW-1:0] ACC_C   = CW'(ACC_W);
  localparam logic [CW-1:0] OUT_C   = CW'(OUT_W);
  localparam logic [CW-1:0] RDY_LIM = CW'(ACC_W - MAX_LEN);

  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               flush_pend_reg, flush_pend_next;
  logic               flush_done_reg, flush_done_next;

  logic [LW-1:0]      len_eff;
  logic [MAX_LEN-1:0] code_masked;
  logic [ACC_W-1:0]   code_ext;
  logic [ACC_W-1:0]   placed;
  logic [ACC_W-1:0]   acc_after;
  logic [CW-1:0]      popped;
  logic [CW-1:0]      cnt_after;
  logic [CW-1:0]      shamt;
  logic               take;
  logic               accept;

  assign len_eff = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;

  // Stray bits above the codeword length are dropped before they reach acc.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign code_masked[gi] = code_in[gi] && (len_eff > LW'(gi));
    end
  endgenerate

  assign code_ext = {{(ACC_W - MAX_LEN){1'b0}}, code_masked};

  assign in_ready  = (cnt_reg <= RDY_LIM) && !flush_pend_reg;
  assign out_valid = (cnt_reg >= OUT_C) || (flush_pend_reg && (cnt_reg != '0));
  assign take      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // Pop happens first; the incoming code lands right behind what survives it.
  assign popped    = !take ? '0 : ((cnt_reg >= OUT_C) ? OUT_C : cnt_reg);
  assign cnt_after = cnt_reg - popped;
  assign acc_after = take ? (acc_reg << OUT_W) : acc_reg;
  assign shamt     = ACC_C - cnt_after - CW'(len_eff);
  assign placed    = code_ext << shamt;

  always_comb begin
    acc_next = acc_after;
    cnt_next = cnt_after;
    if (accept) begin
      acc_next = acc_after | placed;
      cnt_next = cnt_after + CW'(len_eff);
    end
  end

  // A flush completes on the same edge that empties the buffer.
  always_comb begin
    flush_pend_next = flush_pend_reg;
    flush_done_next = 1'b0;
    if (flush_pend_reg) begin
      if (cnt_next == '0) begin
        flush_pend_next = 1'b0;
        flush_done_next = 1'b1;
      end
    end else if (flush) begin
      flush_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      flush_pend_reg <= flush_pend_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // Positions past cnt are forced low so partial words are zero-padded.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_out
      assign out_data[gi] = acc_reg[ACC_W-OUT_W+gi] && (cnt_reg > CW'(OUT_W - 1 - gi));
    end
  endgenerate

  assign out_nbits  = !out_valid ? '0 : ((cnt_reg >= OUT_C) ? NW'(OUT_W) : NW'(cnt_reg));
  assign out_last   = flush_pend_reg && out_valid && (cnt_reg <= OUT_C);
  assign flush_done = flush_done_reg;

endmodule
